// File: rtl/hash_bucket_lookup.sv
// Hash bucket lookup: an accepted hash reads a rule ID from the bucket RAM
// two cycles later. Nonzero rules go into a small output FIFO together with
// their position tag. A reservation counter covers FIFO entries plus lookups
// still in flight, and it stalls the upstream hash pipeline through ce_out
// so that the FIFO can never overflow.
module hash_bucket_lookup #(
  parameter int NBITS      = 15,
  parameter int RULE_W     = 16,
  parameter int TAG_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBITS-1:0]  in_hash,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_v,
  output logic              ce_out,
  input  logic              cfg_we,
  input  logic [NBITS-1:0]  cfg_addr,
  input  logic [RULE_W-1:0] cfg_data,
  output logic [RULE_W-1:0] out_rule,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       hit_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [RULE_W-1:0]       bucket_ram [2**NBITS];
  logic [RULE_W+TAG_W-1:0] fifo_mem [FIFO_DEPTH];

  logic                    cfg_we_q;
  logic [NBITS-1:0]        cfg_addr_q;
  logic [RULE_W-1:0]       cfg_data_q;

  logic                    vld_p1_q, vld_p2_q;
  logic [NBITS-1:0]        addr_p1_q;
  logic [TAG_W-1:0]        tag_p1_q, tag_p2_q;
  logic [RULE_W-1:0]       rule_p2_q;

  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]           reserved_q, reserved_d;
  logic                    ce_q, ce_d;
  logic [31:0]             lookup_cnt_q, hit_cnt_q;

  logic                    accept, hit, miss, push, pop, empty, full;
  logic [RULE_W+TAG_W-1:0] head;

  assign accept = in_v & ce_q;
  assign hit    = vld_p2_q & (rule_p2_q != '0);
  assign miss   = vld_p2_q & (rule_p2_q == '0);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop    = ~empty & out_ready;
  // The reservation scheme keeps the FIFO below full; the guard only
  // protects the stored entries if that invariant were ever broken.
  assign push   = hit & (~full | pop);
  assign head   = fifo_mem[rd_ptr_q[AW-1:0]];

  assign ce_out     = ce_q;
  assign out_valid  = ~empty;
  assign out_rule   = empty ? '0 : head[RULE_W+TAG_W-1:TAG_W];
  assign out_tag    = empty ? '0 : head[TAG_W-1:0];
  assign lookup_cnt = lookup_cnt_q;
  assign hit_cnt    = hit_cnt_q;

  // Config write is delayed one cycle so that a lookup accepted in the
  // same cycle as the write still sees the old bucket contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_we_q <= 1'b0;
    else        cfg_we_q <= cfg_we;
  end

  // Config address/data staging (data path, no reset needed)
  always_ff @(posedge clk) begin
    cfg_addr_q <= cfg_addr;
    cfg_data_q <= cfg_data;
  end

  // Bucket RAM: delayed write port plus registered read (read-before-write)
  always_ff @(posedge clk) begin
    if (cfg_we_q) bucket_ram[cfg_addr_q] <= cfg_data_q;
    rule_p2_q <= bucket_ram[addr_p1_q];
  end

  // Lookup address and tag delay line (data path)
  always_ff @(posedge clk) begin
    addr_p1_q <= in_hash;
    tag_p1_q  <= in_tag;
    tag_p2_q  <= tag_p1_q;
  end

  // In-flight valid bits for the two lookup stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Next reservation count and the registered upstream clock enable
  always_comb begin
    reserved_d = reserved_q + PW'(accept) - PW'(miss) - PW'(pop);
    ce_d       = (reserved_d <= PW'(FIFO_DEPTH - 2));
  end

  // Reservation, clock enable, FIFO pointers and statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved_q   <= '0;
      ce_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lookup_cnt_q <= '0;
      hit_cnt_q    <= '0;
    end else begin
      reserved_q <= reserved_d;
      ce_q       <= ce_d;
      if (push)   wr_ptr_q     <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q     <= rd_ptr_q + PW'(1);
      if (accept) lookup_cnt_q <= lookup_cnt_q + 32'd1;
      if (push)   hit_cnt_q    <= hit_cnt_q + 32'd1;
    end
  end

  // FIFO storage, written with the rule and its tag on each hit
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {rule_p2_q, tag_p2_q};
  end

endmodule

// File: tb/tb_hash_bucket_lookup.sv
// Directed bench for hash_bucket_lookup. Stimulus pushes hand-computed
// expected results into a queue; a monitor pops them whenever the DUT hands
// an entry downstream.
module tb_hash_bucket_lookup;

  localparam int NBITS = 15;
  localparam int RULE_W = 16;
  localparam int TAG_W = 16;
  localparam int FIFO_DEPTH = 16;

  typedef struct packed {
    logic [RULE_W-1:0] rule;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NBITS-1:0]  in_hash;
  logic [TAG_W-1:0]  in_tag;
  logic              in_v;
  logic              ce_out;
  logic              cfg_we;
  logic [NBITS-1:0]  cfg_addr;
  logic [RULE_W-1:0] cfg_data;
  logic [RULE_W-1:0] out_rule;
  logic [TAG_W-1:0]  out_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       lookup_cnt;
  logic [31:0]       hit_cnt;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_lookups = 0;
  int   exp_hits = 0;
  int   accepts;
  int   j;
  int   w;
  logic stress_done;
  logic [4:0] occ;

  logic [NBITS-1:0]  st_addr [8] = '{15'h0010, 15'h0011, 15'h0012, 15'h0013,
                                     15'h0100, 15'h0005, 15'h7FFF, 15'h0000};
  logic [RULE_W-1:0] st_rule [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                     16'h0000, 16'h0003, 16'hFFFF, 16'h0001};

  hash_bucket_lookup #(
    .NBITS(NBITS), .RULE_W(RULE_W), .TAG_W(TAG_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_hash(in_hash), .in_tag(in_tag), .in_v(in_v), .ce_out(ce_out),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_rule(out_rule), .out_tag(out_tag), .out_valid(out_valid),
    .out_ready(out_ready), .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [NBITS-1:0] a, input logic [RULE_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Present one lookup, wait (bounded) for ce_out, record the expectation.
  task automatic issue(input logic [NBITS-1:0] h, input logic [TAG_W-1:0] t,
                       input logic [RULE_W-1:0] rule);
    int waited = 0;
    in_hash = h; in_tag = t; in_v = 1'b1;
    @(negedge clk);
    while (!ce_out && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!ce_out) begin
      vectors++; miscompares++;
      $display("FAIL issue_wait: ce_out stayed 0 for 200 cycles, required 1");
      in_v = 1'b0;
      return;
    end
    @(posedge clk);
    exp_lookups++;
    if (rule != '0) begin
      exp_hits++;
      exp_q.push_back({rule, t});
    end
    #1 in_v = 1'b0;
  endtask

  // Monitor: every entry handed downstream must match the queue head
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_output: got rule 0x%0h tag 0x%0h, required no output",
                   out_rule, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("out_rule", 32'(out_rule), 32'(e.rule));
          chk("out_tag", 32'(out_tag), 32'(e.tag));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_v = 1'b0; in_hash = '0; in_tag = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;
    stress_done = 1'b0;

    // Reset state
    idle(3);
    chk("rst_ce_out", 32'(ce_out), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_rule", 32'(out_rule), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_lookup_cnt", lookup_cnt, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("ce_after_release", 32'(ce_out), 1);
    idle(1);

    // Bucket initialisation
    cfg_write(15'h1234, 16'h00A5);
    cfg_write(15'h0100, 16'h0000);
    cfg_write(15'h0005, 16'h0000);
    cfg_write(15'h7FFF, 16'hFFFF);
    cfg_write(15'h0000, 16'h0001);
    for (int i = 0; i < 32; i++) cfg_write(15'(16 + i), 16'(16'h0100 + i));
    idle(2);

    // Single hit with exact latency
    issue(15'h1234, 16'h0007, 16'h00A5);
    @(negedge clk); chk("hit_valid_t1", 32'(out_valid), 0);
    @(negedge clk); chk("hit_valid_t2", 32'(out_valid), 0);
    @(negedge clk); chk("hit_valid_t3", 32'(out_valid), 1);
    chk("hit_lookup_cnt", lookup_cnt, 1);
    chk("hit_hit_cnt", hit_cnt, 1);
    idle(2);

    // Miss
    issue(15'h0100, 16'h0008, 16'h0000);
    repeat (3) @(negedge clk);
    chk("miss_reserved", 32'(dut.reserved_q), 0);
    chk("miss_out_valid", 32'(out_valid), 0);
    chk("miss_lookup_cnt", lookup_cnt, 2);
    chk("miss_hit_cnt", hit_cnt, 1);
    idle(2);

    // Read during write: same-cycle lookup sees old 0, next one sees 3
    cfg_we = 1'b1; cfg_addr = 15'h0005; cfg_data = 16'h0003;
    issue(15'h0005, 16'h0009, 16'h0000);
    cfg_we = 1'b0;
    issue(15'h0005, 16'h000A, 16'h0003);
    idle(6);
    chk("rdw_lookup_cnt", lookup_cnt, 32'(exp_lookups));
    chk("rdw_hit_cnt", hit_cnt, 32'(exp_hits));

    // Back-to-back mix including extreme address and rule values
    issue(15'h7FFF, 16'hFFFF, 16'hFFFF);
    issue(15'h0000, 16'hABCD, 16'h0001);
    issue(15'h1234, 16'h55AA, 16'h00A5);
    issue(15'h0100, 16'h0001, 16'h0000);
    issue(15'h0010, 16'h0002, 16'h0100);
    idle(6);
    chk("mix_drained", 32'(exp_q.size()), 0);
    chk("mix_lookup_cnt", lookup_cnt, 32'(exp_lookups));
    chk("mix_hit_cnt", hit_cnt, 32'(exp_hits));

    // Backpressure: continuous hits with out_ready low
    out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 40; i++) begin
      in_hash = 15'(16 + i); in_tag = 16'(16'h2000 + i); in_v = 1'b1;
      @(negedge clk);
      if (!ce_out) break;
      @(posedge clk);
      exp_q.push_back({16'(16'h0100 + i), 16'(16'h2000 + i)});
      exp_lookups++; exp_hits++; accepts++;
      #1;
    end
    in_v = 1'b0;
    chk("bp_accepts", 32'(accepts), 15);
    repeat (5) @(negedge clk);
    occ = dut.wr_ptr_q - dut.rd_ptr_q;
    chk("bp_occupancy", 32'(occ), 15);
    chk("bp_ce_out", 32'(ce_out), 0);
    chk("bp_head_rule", 32'(out_rule), 32'h0100);
    chk("bp_head_tag", 32'(out_tag), 32'h2000);
    @(posedge clk); #1 out_ready = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin @(negedge clk); w++; end
    chk("bp_drained", 32'(exp_q.size()), 0);
    idle(2);
    chk("bp_ce_restored", 32'(ce_out), 1);
    chk("bp_hit_cnt", hit_cnt, 32'(exp_hits));

    // Reset mid-stream: 4 FIFO entries and 2 lookups in flight
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++)
      issue(15'(16 + k), 16'(16'h3000 + k), 16'(16'h0100 + k));
    occ = dut.wr_ptr_q - dut.rd_ptr_q;
    chk("mid_occupancy", 32'(occ), 4);
    chk("mid_inflight", 32'({dut.vld_p1_q, dut.vld_p2_q}), 32'h3);
    exp_q.delete();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_ce_out", 32'(ce_out), 0);
    exp_lookups = 0; exp_hits = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ce_after_release", 32'(ce_out), 1);
    chk("mid_lookup_cnt", lookup_cnt, 0);
    chk("mid_hit_cnt", hit_cnt, 0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_no_stale", 32'(out_valid), 0);
    idle(1);
    issue(15'h1234, 16'h0042, 16'h00A5);
    idle(5);
    chk("mid_post_hit_cnt", hit_cnt, 1);

    // Short mixed in_v / out_ready stress over the known bucket table
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 2) != 0) begin
            j = $urandom_range(0, 7);
            issue(st_addr[j], 16'(16'h4000 + i), st_rule[j]);
          end else begin
            idle(1);
          end
        end
        stress_done = 1'b1;
      end
      begin
        while (!stress_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin @(negedge clk); w++; end
    chk("stress_drained", 32'(exp_q.size()), 0);
    idle(3);
    chk("stress_lookup_cnt", lookup_cnt, 32'(exp_lookups));
    chk("stress_hit_cnt", hit_cnt, 32'(exp_hits));
    chk("stress_reserved", 32'(dut.reserved_q), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hash_bucket_lookup.md
HASH_BUCKET_LOOKUP -- requirements
Module: hash_bucket_lookup

Interface
REQ-001 Parameter NBITS, default 15, hash width and bucket RAM address width (2^NBITS entries).
REQ-002 Parameter RULE_W, default 16, rule ID width; rule ID 0 means empty bucket.
REQ-003 Parameter TAG_W, default 16, width of the byte-position tag carried with each hash.
REQ-004 Parameter FIFO_DEPTH, default 16, output FIFO entries, power of two, at least 8.
REQ-005 clk  in  1  single clock; every flop is rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_hash  in  NBITS  hash from the multiplicative-hash stage.
REQ-008 in_tag  in  TAG_W  position tag aligned with in_hash.
REQ-009 in_v  in  1  in_hash/in_tag valid.
REQ-010 ce_out  out  1  clock enable driven to the upstream hash pipeline; 0 stalls it.
REQ-011 cfg_we  in  1  bucket RAM write strobe.
REQ-012 cfg_addr  in  NBITS  bucket RAM write address.
REQ-013 cfg_data  in  RULE_W  rule ID to write.
REQ-014 out_rule  out  RULE_W  matched rule ID (FIFO head).
REQ-015 out_tag  out  TAG_W  tag of the matched hash.
REQ-016 out_valid  out  1  FIFO head valid.
REQ-017 out_ready  in  1  downstream accepts head; pop on out_valid&out_ready.
REQ-018 lookup_cnt  out  32  count of accepted lookups; wraps modulo 2^32.
REQ-019 hit_cnt  out  32  count of nonzero-rule results pushed to the FIFO; wraps modulo 2^32.

Function
REQ-020 A lookup is accepted in cycle T iff in_v=1 and ce_out=1; in_v is ignored while ce_out=0, because upstream holds its output frozen.
REQ-021 Accepted hash addresses the bucket RAM.
  - Address is registered at T+1.
  - RAM data is registered at T+2.
  - Result is pushed to the FIFO at the end of T+2, with its tag carried in a matching 2-stage delay line.
REQ-022 A result with rule ID 0 is a miss: it is discarded, nothing is pushed, and hit_cnt is unchanged.
REQ-023 The FIFO does not fall through. Earliest out_valid for a hit accepted at T, into an empty FIFO, is T+3.
REQ-024 FIFO order equals acceptance order.
  - out_rule and out_tag stay stable while out_valid=1 and out_ready=0.
REQ-025 The reserved count is FIFO occupancy plus lookups in flight (0..2).
  - It increments on accept.
  - It decrements on a miss at RAM return and on each FIFO pop.
  - Simultaneous events net correctly.
REQ-026 ce_out is registered. ce_out is 1 in the next cycle iff next-state reserved count ≤ FIFO_DEPTH-2. This guarantees the FIFO never overflows.
REQ-027 Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
  - Pop on an empty FIFO cannot occur, since out_valid=0.
REQ-028 Config write is a simple dual-port write, usable at any time.
  - A lookup reading the same address in the same cycle returns the old data.
  - A later read returns the new data.
REQ-029 lookup_cnt increments on every accept. hit_cnt increments on every push.
REQ-030 FIFO read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full and empty are derived from the MSB and index compare.

Reset
REQ-031 While rst_n=0 the following hold:
  - ce_out=0 and out_valid=0.
  - FIFO is empty.
  - In-flight valid bits are 0.
  - reserved=0.
  - lookup_cnt=0 and hit_cnt=0.
  - out_rule and out_tag are 0.
REQ-032 ce_out rises in the first clock edge after rst_n deasserts.
REQ-033 Bucket RAM contents are not reset; software initialises them through the cfg port.
REQ-034 Reset asserted mid-operation discards all in-flight lookups and FIFO contents immediately; no partial result is emitted after release.

Verification
REQ-035 Single hit: write addr 0x1234=0x00A5; accept hash 0x1234, tag 0x0007 at T with out_ready=1 -> out_valid at T+3 with rule 0x00A5 and tag 0x0007; lookup_cnt=1, hit_cnt=1.
REQ-036 Miss: hash to an address holding 0 -> no out_valid; lookup_cnt increments; hit_cnt unchanged; reserved returns to 0 by T+3.
REQ-037 Backpressure: out_ready=0 with in_v=1 continuously on hit addresses -> ce_out drops after at most FIFO_DEPTH-1 accepts; FIFO never exceeds FIFO_DEPTH; releasing out_ready drains all results in order with no loss or duplicate.
REQ-038 Read-during-write: cfg write of 0x0003 to addr 5 in the same cycle a lookup of addr 5 is accepted, old value 0 -> miss; next lookup of addr 5 -> rule 0x0003.
REQ-039 Reset mid-stream: assert rst_n=0 with 2 lookups in flight and 4 FIFO entries -> out_valid=0 at once; after release ce_out=1 next edge, counters 0, no stale output.
REQ-040 Random in_v/out_ready stress over 10^5 cycles against a scoreboard model -> exact match of rule/tag sequence and counters.
